audio_rx_deser: RTL and testbench

//  Parametrised serial-audio receiver for the CODEC ADC path; replaces the single-channel, 16-bit, LJ-only capture.

---
 rtl/audio_pkg.sv | 24 ++
 rtl/audio_lrc_edge.sv | 32 +++
 rtl/audio_rx_deser.sv | 137 +++++++++++++
 tb/tb_audio_rx_deser.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types for the CODEC serial-audio path (ADC receiver, future DAC transmitter).
//   fmt_e      : serial framing, left-justified or I2S
//   ch_e       : stereo channel tag carried with each sample
//   rx_state_e : receiver capture FSM states
package audio_pkg;

   typedef enum logic {
      FMT_LJ  = 1'b0,
      FMT_I2S = 1'b1
   } fmt_e;

   typedef enum logic {
      CH_LEFT  = 1'b0,
      CH_RIGHT = 1'b1
   } ch_e;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      SHIFT,
      HOLD
   } rx_state_e;

endpackage

// File: rtl/audio_lrc_edge.sv
// LR-clock edge detector shared by the ADC receiver and DAC transmitter.
// Ports:
//   bclk     in  bit clock
//   reset    in  synchronous active-high reset
//   adclrc   in  LR clock, synchronous to bclk; high = left, low = right
//   lrc_edge out high in any cycle where adclrc differs from its registered copy
//   edge_ch  out channel that starts at this edge (rising = left, falling = right)
module audio_lrc_edge
   import audio_pkg::*;
(
   input  logic bclk,
   input  logic reset,
   input  logic adclrc,
   output logic lrc_edge,
   output ch_e  edge_ch
);

   logic adclrc_q;

   // Reset also loads the live level so that no edge is reported right after reset.
   always_ff @(posedge bclk) begin
      if (reset) begin
         adclrc_q <= adclrc;
      end else begin
         adclrc_q <= adclrc;
      end
   end

   assign lrc_edge = adclrc ^ adclrc_q;
   assign edge_ch  = adclrc ? CH_LEFT : CH_RIGHT;

endmodule

// File: rtl/audio_rx_deser.sv
// Stereo serial-audio receiver for the CODEC ADC path.
// Deserialises adcdat MSB-first in left-justified or I2S framing and emits one sign-extended
// sample per channel, plus a pulse when an LR edge truncates a word.
// Ports:
//   bclk        in  bit clock, rising edge only
//   reset       in  synchronous active-high reset
//   adclrc      in  LR clock; high = left, low = right
//   adcdat      in  serial data, MSB first
//   valid       out one-cycle pulse, new sample_data/channel
//   channel     out 0 = left, 1 = right; qualified by valid
//   sample_data out sign-extended sample, held until the next valid
//   frame_err   out one-cycle pulse, word cut short by an LR edge
module audio_rx_deser
   import audio_pkg::*;
#(
   parameter int unsigned N       = 16,
   parameter int unsigned OUT_W   = 16,
   parameter fmt_e        FMT     = FMT_LJ,
   parameter logic [1:0]  CH_MASK = 2'b11
) (
   input  logic             bclk,
   input  logic             reset,
   input  logic             adclrc,
   input  logic             adcdat,
   output logic             valid,
   output logic             channel,
   output logic [OUT_W-1:0] sample_data,
   output logic             frame_err
);

   localparam int unsigned    CntW    = $clog2(N + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

   if (OUT_W < N) begin : g_bad_out_w
      $error("audio_rx_deser: OUT_W must be >= N");
   end
   if (N < 8 || N > 32) begin : g_bad_n
      $error("audio_rx_deser: N must be in 8..32");
   end

   logic lrc_edge;
   ch_e  edge_ch;

   audio_lrc_edge u_lrc_edge (
      .bclk     (bclk),
      .reset    (reset),
      .adclrc   (adclrc),
      .lrc_edge (lrc_edge),
      .edge_ch  (edge_ch)
   );

   rx_state_e        state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]     rx_q, rx_d;
   ch_e              ch_q, ch_d;
   logic             valid_q, valid_d;
   ch_e              out_ch_q, out_ch_d;
   logic [OUT_W-1:0] data_q, data_d;
   logic             ferr_q, ferr_d;
   logic [N-1:0]     word;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rx_d     = rx_q;
      ch_d     = ch_q;
      valid_d  = 1'b0;
      out_ch_d = out_ch_q;
      data_d   = data_q;
      ferr_d   = 1'b0;
      word     = {rx_q[N-2:0], adcdat};

      if (lrc_edge) begin
         // An edge always restarts capture; a word still in flight is dropped.
         ferr_d = (state_q == SHIFT) || (state_q == DELAY);
         ch_d   = edge_ch;
         if (FMT == FMT_LJ) begin
            state_d = SHIFT;
            cnt_d   = CntW'(1);
            rx_d    = N'(adcdat);
         end else begin
            state_d = DELAY;
            cnt_d   = '0;
         end
      end else begin
         unique case (state_q)
            DELAY: begin
               state_d = SHIFT;
               cnt_d   = CntW'(1);
               rx_d    = N'(adcdat);
            end
            SHIFT: begin
               rx_d  = word;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LastCnt) begin
                  state_d = HOLD;
                  // Masked channels still run capture but never publish a sample.
                  if (CH_MASK[ch_q]) begin
                     valid_d  = 1'b1;
                     out_ch_d = ch_q;
                     data_d   = OUT_W'(signed'(word));
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge bclk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rx_q     <= '0;
         ch_q     <= CH_LEFT;
         valid_q  <= 1'b0;
         out_ch_q <= CH_LEFT;
         data_q   <= '0;
         ferr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rx_q     <= rx_d;
         ch_q     <= ch_d;
         valid_q  <= valid_d;
         out_ch_q <= out_ch_d;
         data_q   <= data_d;
         ferr_q   <= ferr_d;
      end
   end

   assign valid       = valid_q;
   assign channel     = out_ch_q;
   assign sample_data = data_q;
   assign frame_err   = ferr_q;

endmodule

// File: tb/tb_audio_rx_deser.sv
module tb_audio_rx_deser;
   import audio_pkg::*;

   logic bclk = 1'b0;
   logic reset;
   logic adclrc;
   logic adcdat;

   always #5 bclk = ~bclk;

   logic        lj_v, lj_ch, lj_fe;
   logic [15:0] lj_d;
   logic        i2_v, i2_ch, i2_fe;
   logic [15:0] i2_d;
   logic        w_v, w_ch, w_fe;
   logic [31:0] w_d;
   logic        m_v, m_ch, m_fe;
   logic [15:0] m_d;

   audio_rx_deser #(.N(16), .OUT_W(16), .FMT(FMT_LJ), .CH_MASK(2'b11)) u_lj (
      .bclk(bclk), .reset(reset), .adclrc(adclrc), .adcdat(adcdat),
      .valid(lj_v), .channel(lj_ch), .sample_data(lj_d), .frame_err(lj_fe));

   audio_rx_deser #(.N(16), .OUT_W(16), .FMT(FMT_I2S), .CH_MASK(2'b11)) u_i2s (
      .bclk(bclk), .reset(reset), .adclrc(adclrc), .adcdat(adcdat),
      .valid(i2_v), .channel(i2_ch), .sample_data(i2_d), .frame_err(i2_fe));

   audio_rx_deser #(.N(24), .OUT_W(32), .FMT(FMT_LJ), .CH_MASK(2'b11)) u_w24 (
      .bclk(bclk), .reset(reset), .adclrc(adclrc), .adcdat(adcdat),
      .valid(w_v), .channel(w_ch), .sample_data(w_d), .frame_err(w_fe));

   audio_rx_deser #(.N(16), .OUT_W(16), .FMT(FMT_LJ), .CH_MASK(2'b01)) u_msk (
      .bclk(bclk), .reset(reset), .adclrc(adclrc), .adcdat(adcdat),
      .valid(m_v), .channel(m_ch), .sample_data(m_d), .frame_err(m_fe));

   // Monitor mux: 0 = LJ, 1 = I2S, 2 = 24-bit, 3 = masked.
   int          sel;
   logic        mon_v, mon_ch, mon_fe;
   logic [31:0] mon_d;

   always_comb begin
      mon_v  = lj_v;
      mon_ch = lj_ch;
      mon_fe = lj_fe;
      mon_d  = {16'h0, lj_d};
      case (sel)
         1: begin mon_v = i2_v; mon_ch = i2_ch; mon_fe = i2_fe; mon_d = {16'h0, i2_d}; end
         2: begin mon_v = w_v;  mon_ch = w_ch;  mon_fe = w_fe;  mon_d = w_d; end
         3: begin mon_v = m_v;  mon_ch = m_ch;  mon_fe = m_fe;  mon_d = {16'h0, m_d}; end
         default: ;
      endcase
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic step(input logic lrc, input logic dat);
      adclrc = lrc;
      adcdat = dat;
      @(posedge bclk);
      #1;
   endtask

   task automatic idle(input logic lrc, input int n);
      for (int i = 0; i < n; i++) step(lrc, 1'b0);
   endtask

   task automatic do_reset(input logic lrc);
      reset = 1'b1;
      step(lrc, 1'b0);
      step(lrc, 1'b0);
      reset = 1'b0;
      idle(lrc, 3);
   endtask

   // Drives one LR slot: dly idle bits, then word MSB-first, then padding ones.
   // Records the first valid (step index, data, channel) and frame_err pulses seen.
   task automatic send_slot(input logic lrc, input logic [31:0] word, input int nbits,
                            input int len, input int dly, output int nv, output int vpos,
                            output logic [31:0] vdata, output logic vch, output int nf,
                            output int fpos);
      int idx;
      nv = 0; vpos = -1; vdata = '0; vch = 1'b0; nf = 0; fpos = -1;
      for (int i = 0; i < len; i++) begin
         idx = i - dly;
         step(lrc, (idx >= 0 && idx < nbits) ? word[nbits-1-idx] : 1'b1);
         if (mon_v) begin
            if (nv == 0) begin vpos = i; vdata = mon_d; vch = mon_ch; end
            nv++;
         end
         if (mon_fe) begin
            if (nf == 0) fpos = i;
            nf++;
         end
      end
   endtask

   int          nv, vpos, nf, fpos;
   logic [31:0] vd;
   logic        vc;

   task automatic test_reset();
      sel = 0;
      reset = 1'b1;
      step(1'b0, 1'b1);
      n_chk++; if ({lj_v, lj_ch, lj_fe, lj_d} !== 19'h0)
         $display("FAIL reset_lj_outputs: got %h want 0", {lj_v, lj_ch, lj_fe, lj_d}); else n_pass++;
      n_chk++; if ({w_v, w_ch, w_fe, w_d} !== 35'h0)
         $display("FAIL reset_w24_outputs: got %h want 0", {w_v, w_ch, w_fe, w_d}); else n_pass++;
      reset = 1'b0;
      send_slot(1'b0, 32'h0, 16, 8, 0, nv, vpos, vd, vc, nf, fpos);
      n_chk++; if (nv + nf !== 0)
         $display("FAIL reset_no_false_edge: got %0d pulses want 0", nv + nf); else n_pass++;
   endtask

   task automatic test_lj();
      sel = 0;
      do_reset(1'b0);
      send_slot(1'b1, 32'hA5C3, 16, 32, 0, nv, vpos, vd, vc, nf, fpos);
      n_chk++; if (nv !== 1 || vpos !== 15)
         $display("FAIL lj_left_timing: got n=%0d pos=%0d want n=1 pos=15", nv, vpos); else n_pass++;
      n_chk++; if (vd !== 32'hA5C3 || vc !== 1'b0)
         $display("FAIL lj_left_data: got %h ch%0d want a5c3 ch0", vd, vc); else n_pass++;
      send_slot(1'b0, 32'h8001, 16, 32, 0, nv, vpos, vd, vc, nf, fpos);
      n_chk++; if (nv !== 1 || vpos !== 15 || nf !== 0)
         $display("FAIL lj_right_timing: got n=%0d pos=%0d fe=%0d want 1/15/0", nv, vpos, nf);
      else n_pass++;
      n_chk++; if (vd !== 32'h8001 || vc !== 1'b1)
         $display("FAIL lj_right_data: got %h ch%0d want 8001 ch1", vd, vc); else n_pass++;
      n_chk++; if (lj_d !== 16'h8001)
         $display("FAIL lj_data_held: got %h want 8001", lj_d); else n_pass++;
   endtask

   task automatic test_i2s();
      sel = 1;
      do_reset(1'b0);
      send_slot(1'b1, 32'hA5C3, 16, 32, 1, nv, vpos, vd, vc, nf, fpos);
      n_chk++; if (nv !== 1 || vpos !== 16 || vd !== 32'hA5C3 || vc !== 1'b0)
         $display("FAIL i2s_left: got n=%0d pos=%0d %h ch%0d want 1/16/a5c3/0", nv, vpos, vd, vc);
      else n_pass++;
      send_slot(1'b0, 32'h8001, 16, 32, 1, nv, vpos, vd, vc, nf, fpos);
      n_chk++; if (nv !== 1 || vpos !== 16 || vd !== 32'h8001 || vc !== 1'b1)
         $display("FAIL i2s_right: got n=%0d pos=%0d %h ch%0d want 1/16/8001/1", nv, vpos, vd, vc);
      else n_pass++;
   endtask

   task automatic test_width24();
      sel = 2;
      do_reset(1'b1);
      send_slot(1'b0, 32'h800000, 24, 32, 0, nv, vpos, vd, vc, nf, fpos);
      n_chk++; if (nv !== 1 || vpos !== 23 || vd !== 32'hFF800000 || vc !== 1'b1)
         $display("FAIL w24_right_neg: got n=%0d pos=%0d %h ch%0d want 1/23/ff800000/1",
                  nv, vpos, vd, vc);
      else n_pass++;
      send_slot(1'b1, 32'h123456, 24, 32, 0, nv, vpos, vd, vc, nf, fpos);
      n_chk++; if (nv !== 1 || vd !== 32'h00123456 || vc !== 1'b0)
         $display("FAIL w24_left_pos: got n=%0d %h ch%0d want 1/00123456/0", nv, vd, vc);
      else n_pass++;
   endtask

   task automatic test_short_frame();
      sel = 0;
      do_reset(1'b0);
      send_slot(1'b1, 32'hFFFF, 16, 10, 0, nv, vpos, vd, vc, nf, fpos);
      n_chk++; if (nv !== 0 || nf !== 0)
         $display("FAIL short_partial: got v=%0d fe=%0d want 0/0", nv, nf); else n_pass++;
      send_slot(1'b0, 32'h1234, 16, 32, 0, nv, vpos, vd, vc, nf, fpos);
      n_chk++; if (nf !== 1 || fpos !== 0)
         $display("FAIL short_frame_err: got n=%0d pos=%0d want 1/0", nf, fpos); else n_pass++;
      n_chk++; if (nv !== 1 || vd !== 32'h1234 || vc !== 1'b1)
         $display("FAIL short_next_word: got n=%0d %h ch%0d want 1/1234/1", nv, vd, vc);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      sel = 0;
      do_reset(1'b0);
      send_slot(1'b1, 32'hA5C3, 16, 16, 0, nv, vpos, vd, vc, nf, fpos);
      n_chk++; if (nv !== 1 || vpos !== 15 || vd !== 32'hA5C3)
         $display("FAIL b2b_left: got n=%0d pos=%0d %h want 1/15/a5c3", nv, vpos, vd);
      else n_pass++;
      send_slot(1'b0, 32'h8001, 16, 16, 0, nv, vpos, vd, vc, nf, fpos);
      n_chk++; if (nv !== 1 || vd !== 32'h8001 || vc !== 1'b1 || nf !== 0)
         $display("FAIL b2b_right: got n=%0d %h ch%0d fe=%0d want 1/8001/1/0", nv, vd, vc, nf);
      else n_pass++;
   endtask

   task automatic test_mask();
      sel = 3;
      do_reset(1'b0);
      send_slot(1'b1, 32'h1357, 16, 32, 0, nv, vpos, vd, vc, nf, fpos);
      n_chk++; if (nv !== 1 || vd !== 32'h1357 || vc !== 1'b0)
         $display("FAIL mask_left: got n=%0d %h ch%0d want 1/1357/0", nv, vd, vc); else n_pass++;
      send_slot(1'b0, 32'hBEEF, 16, 32, 0, nv, vpos, vd, vc, nf, fpos);
      n_chk++; if (nv !== 0)
         $display("FAIL mask_right_suppressed: got %0d valids want 0", nv); else n_pass++;
      send_slot(1'b1, 32'h2468, 16, 32, 0, nv, vpos, vd, vc, nf, fpos);
      n_chk++; if (nv !== 1 || vd !== 32'h2468 || vc !== 1'b0)
         $display("FAIL mask_left2: got n=%0d %h ch%0d want 1/2468/0", nv, vd, vc); else n_pass++;
   endtask

   task automatic test_mid_reset();
      sel = 0;
      do_reset(1'b0);
      send_slot(1'b1, 32'hA5C3, 16, 32, 0, nv, vpos, vd, vc, nf, fpos);
      send_slot(1'b0, 32'h8001, 16, 8, 0, nv, vpos, vd, vc, nf, fpos);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1);
         n_chk++; if ({lj_v, lj_ch, lj_fe, lj_d} !== 19'h0)
            $display("FAIL midreset_outputs: got %h want 0", {lj_v, lj_ch, lj_fe, lj_d});
         else n_pass++;
      end
      reset = 1'b0;
      send_slot(1'b0, 32'hFFFF, 16, 20, 0, nv, vpos, vd, vc, nf, fpos);
      n_chk++; if (nv !== 0 || nf !== 0)
         $display("FAIL midreset_quiet: got v=%0d fe=%0d want 0/0", nv, nf); else n_pass++;
      send_slot(1'b1, 32'h5A3C, 16, 32, 0, nv, vpos, vd, vc, nf, fpos);
      n_chk++; if (nv !== 1 || vpos !== 15 || vd !== 32'h5A3C || nf !== 0)
         $display("FAIL midreset_resume: got n=%0d pos=%0d %h fe=%0d want 1/15/5a3c/0",
                  nv, vpos, vd, nf);
      else n_pass++;
   endtask

   initial begin
      sel    = 0;
      reset  = 1'b1;
      adclrc = 1'b0;
      adcdat = 1'b0;
      #1;
      test_reset();
      test_lj();
      test_i2s();
      test_width24();
      test_short_frame();
      test_back_to_back();
      test_mask();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
